// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
//   Bundles every signal between the ALU issue stage and its neighbours
//   (instruction source, register file read ports, ALU, write-back port).
//
//   modport master : the issue stage itself
//   modport slave  : the environment (instruction source, regfile, ALU)
//
//   Signals
//     instr_valid / instr / instr_ready : instruction handshake
//     rs1_addr / rs2_addr               : regfile read addresses (comb)
//     rs1_data / rs2_data               : regfile read data (comb)
//     alu_en / op_val / a / b           : ALU start pulse, op code, operands
//     alu_done / alu_out                : ALU completion and result
//     wb_en / wb_addr / wb_data         : regfile write-back strobe
//     illegal / timeout                 : one-cycle error pulses
// ---------------------------------------------------------------------------
interface alu_issue_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        alu_en;
  logic [3:0]  op_val;
  logic [31:0] a;
  logic [31:0] b;
  logic        alu_done;
  logic [31:0] alu_out;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic        timeout;

  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, alu_done, alu_out,
    output instr_ready, rs1_addr, rs2_addr, alu_en, op_val, a, b,
           wb_en, wb_addr, wb_data, illegal, timeout
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, alu_done, alu_out,
    input  instr_ready, rs1_addr, rs2_addr, alu_en, op_val, a, b,
           wb_en, wb_addr, wb_data, illegal, timeout
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Decode/issue stage in front of the ALU. Accepts RV32I OP / OP-IMM
//   instructions, reads rs1/rs2, launches the ALU with a one-cycle alu_en,
//   waits (bounded) for alu_done and writes the result back in one cycle.
//   FSM: IDLE -> ISSUE -> WAIT -> WB -> IDLE.
//
//   Parameters
//     TIMEOUT_CYCLES : WAIT cycles allowed for alu_done before abort (>=2)
//
//   Ports
//     ck_ref : clock, rising edge
//     rst    : asynchronous, active-high reset
//     bus    : alu_issue_if.master (handshake, regfile, ALU, write-back)
//
//   Configuration macro
//     ALU_ISSUE_BYPASS_EN : when defined, the last written (rd, data) pair is
//       held and forwarded to rs1/rs2 on accept, covering a regfile that
//       commits on the write-back edge. Undefined: operands always come
//       straight from rs1_data/rs2_data.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        ck_ref,
  input  logic        rst,
  alu_issue_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0011, OP_OR  = 4'b0100,
    OP_XOR  = 4'b0101, OP_SLL = 4'b0110, OP_SRL = 4'b0111, OP_SRA = 4'b1000,
    OP_SLT  = 4'b1001, OP_SLTU = 4'b1010
  } alu_op_t;

  localparam int            CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;

  logic [4:0]  rd_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        illegal_q;

  logic        accept;
  logic        expired;
  logic        dec_legal;
  alu_op_t     dec_op;
  logic [31:0] dec_b;
  logic [31:0] rs1_val, rs2_val;

  // Register file addresses come straight from the instruction word.
  assign bus.rs1_addr = bus.instr[19:15];
  assign bus.rs2_addr = bus.instr[24:20];

  // -------------------------------------------------------------------------
  // Operand source (optional forwarding of the last write-back)
  // -------------------------------------------------------------------------
`ifdef ALU_ISSUE_BYPASS_EN
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;

  always_ff @(posedge ck_ref or posedge rst) begin
    if (rst) begin
      byp_rd   <= '0;
      byp_data <= '0;
    end else if (state == S_WB && rd_q != 5'd0) begin
      byp_rd   <= rd_q;
      byp_data <= wb_data_q;
    end
  end

  // x0 is never forwarded: byp_rd stays 0 until a real write happens.
  assign rs1_val = (byp_rd != 5'd0 && byp_rd == bus.rs1_addr) ? byp_data : bus.rs1_data;
  assign rs2_val = (byp_rd != 5'd0 && byp_rd == bus.rs2_addr) ? byp_data : bus.rs2_data;
`else
  assign rs1_val = bus.rs1_data;
  assign rs2_val = bus.rs2_data;
`endif

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  always_comb begin
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       is_op, is_imm, is_shift, f7_ok;

    // NOTE: every variable gets a default before any branch, so no path
    // through this block can leave a value unassigned and infer a latch.
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_b     = '0;

    opcode   = bus.instr[6:0];
    funct3   = bus.instr[14:12];
    funct7   = bus.instr[31:25];
    is_op    = (opcode == 7'b0110011);
    is_imm   = (opcode == 7'b0010011);
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    // 0100000 is only meaningful for SUB (register form) and SRA/SRAI.
    f7_ok    = (funct7 == 7'b0000000) ||
               (funct7 == 7'b0100000 &&
                (funct3 == 3'b101 || (is_op && funct3 == 3'b000)));

    if (is_op)       dec_legal = f7_ok;
    else if (is_imm) dec_legal = is_shift ? f7_ok : 1'b1;

    unique case (funct3)
      3'b000:  dec_op = (is_op && funct7[5]) ? OP_SUB : OP_ADD;
      3'b001:  dec_op = OP_SLL;
      3'b010:  dec_op = OP_SLT;
      3'b011:  dec_op = OP_SLTU;
      3'b100:  dec_op = OP_XOR;
      3'b101:  dec_op = funct7[5] ? OP_SRA : OP_SRL;
      3'b110:  dec_op = OP_OR;
      default: dec_op = OP_AND;
    endcase

    if (is_op)         dec_b = rs2_val;
    else if (is_shift) dec_b = {27'b0, bus.instr[24:20]};
    else               dec_b = {{20{bus.instr[31]}}, bus.instr[31:20]};
  end

  assign accept  = (state == S_IDLE) && bus.instr_valid;
  assign expired = (wait_cnt == CNT_LAST);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge ck_ref or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept && dec_legal) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      // alu_done is checked first so a late done in the expiry cycle wins.
      S_WAIT:  if (bus.alu_done)  state_next = S_WB;
               else if (expired) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // Ready is masked while rst is held so every output reads 0 in reset.
    bus.instr_ready = (state == S_IDLE) && !rst;
    bus.alu_en      = (state == S_ISSUE);
    bus.wb_en       = (state == S_WB) && (rd_q != 5'd0);
    bus.timeout     = (state == S_WAIT) && expired && !bus.alu_done;
  end

  assign bus.op_val  = op_q;
  assign bus.a       = a_q;
  assign bus.b       = b_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;
  assign bus.illegal = illegal_q;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge ck_ref or posedge rst) begin
    if (rst) begin
      rd_q      <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      illegal_q <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      illegal_q <= accept && !dec_legal;

      // Operands only move on a legal accept, so they stay stable through
      // ISSUE and WAIT.
      if (accept && dec_legal) begin
        rd_q <= bus.instr[11:7];
        op_q <= dec_op;
        a_q  <= rs1_val;
        b_q  <= dec_b;
      end

      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;

      // Write-back address/data load on the way into WB and then hold.
      if (state == S_WAIT && bus.alu_done) begin
        wb_addr_q <= rd_q;
        wb_data_q <= bus.alu_out;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//   Directed bench for alu_issue_stage. Stimulus pushes the expected ALU
//   issue (op, a, b) and the expected terminal event (write-back, illegal,
//   timeout) into queues; a negedge monitor pops and compares whenever the
//   DUT presents alu_en, wb_en, illegal or timeout. A small responder plays
//   the ALU with a per-vector done delay; a bench array plays the regfile.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic ck_ref = 1'b0;
  logic rst    = 1'b1;
  always #5 ck_ref = ~ck_ref;

  alu_issue_if bus ();

  alu_issue_stage #(.TIMEOUT_CYCLES(16)) dut (
    .ck_ref (ck_ref),
    .rst    (rst),
    .bus    (bus)
  );

  typedef enum logic [2:0] {EV_WB = 3'b100, EV_ILL = 3'b010, EV_TO = 3'b001} ev_kind_t;
  typedef struct {logic [3:0] op; logic [31:0] a; logic [31:0] b;} issue_t;
  typedef struct {ev_kind_t kind; logic [4:0] addr; logic [31:0] data;} res_t;

  issue_t issue_q[$];
  res_t   res_q[$];

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] regs [32];
  int          alu_delay = 1;   // -1 never, 0 pulse during ISSUE only, k: WAIT cycle k

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Register file read ports.
  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    bus.rs2_data = regs[bus.rs2_addr];
  end

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0001: return a + b;
      4'b0010: return a - b;
      4'b0011: return a & b;
      4'b0100: return a | b;
      4'b0101: return a ^ b;
      4'b0110: return a << b[4:0];
      4'b0111: return a >> b[4:0];
      4'b1000: return $unsigned($signed(a) >>> b[4:0]);
      4'b1001: return {31'b0, $signed(a) < $signed(b)};
      4'b1010: return {31'b0, a < b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // ALU responder.
  initial begin
    int d;
    bus.alu_done = 1'b0;
    bus.alu_out  = '0;
    forever begin
      @(negedge ck_ref);
      if (bus.alu_en && !rst) begin
        d = alu_delay;
        if (d >= 0) begin
          repeat (d) @(negedge ck_ref);
          bus.alu_done = 1'b1;
          bus.alu_out  = alu_ref(bus.op_val, bus.a, bus.b);
          @(negedge ck_ref);
          bus.alu_done = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  issue_t mon_i;
  res_t   mon_r;
  always @(negedge ck_ref) begin
    if (!rst) begin
      if (bus.alu_en) begin
        if (issue_q.size() == 0) check("alu_en_unexpected", {31'b0, bus.alu_en}, 32'd0);
        else begin
          mon_i = issue_q.pop_front();
          check("op_val", {28'b0, bus.op_val}, {28'b0, mon_i.op});
          check("a", bus.a, mon_i.a);
          check("b", bus.b, mon_i.b);
        end
      end
      if (bus.wb_en || bus.illegal || bus.timeout) begin
        if (res_q.size() == 0)
          check("event_unexpected", {29'b0, bus.wb_en, bus.illegal, bus.timeout}, 32'd0);
        else begin
          mon_r = res_q.pop_front();
          check("event_kind", {29'b0, bus.wb_en, bus.illegal, bus.timeout}, {29'b0, mon_r.kind});
          if (mon_r.kind == EV_WB) begin
            check("wb_addr", {27'b0, bus.wb_addr}, {27'b0, mon_r.addr});
            check("wb_data", bus.wb_data, mon_r.data);
          end
        end
      end
    end
  end

  task automatic exp_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue_t e;
    e.op = op; e.a = a; e.b = b;
    issue_q.push_back(e);
  endtask

  task automatic exp_event(input ev_kind_t kind, input logic [4:0] addr, input logic [31:0] data);
    res_t r;
    r.kind = kind; r.addr = addr; r.data = data;
    res_q.push_back(r);
  endtask

  // Present one instruction and return just after the accepting edge.
  task automatic send(input logic [31:0] ins, input int delay);
    int n = 0;
    alu_delay = delay;
    @(negedge ck_ref);
    while (!bus.instr_ready && n < 60) begin
      @(negedge ck_ref);
      n++;
    end
    check("ready_before_send", {31'b0, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge ck_ref);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge ck_ref);
      n++;
    end while (!bus.instr_ready && n < 60);
    check("return_to_idle", {31'b0, bus.instr_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_ready"}, {31'b0, bus.instr_ready}, 32'd0);
    check({tag, "_alu_en"},      {31'b0, bus.alu_en},      32'd0);
    check({tag, "_op_val"},      {28'b0, bus.op_val},      32'd0);
    check({tag, "_a"},           bus.a,                    32'd0);
    check({tag, "_b"},           bus.b,                    32'd0);
    check({tag, "_wb_en"},       {31'b0, bus.wb_en},       32'd0);
    check({tag, "_wb_addr"},     {27'b0, bus.wb_addr},     32'd0);
    check({tag, "_wb_data"},     bus.wb_data,              32'd0);
    check({tag, "_illegal"},     {31'b0, bus.illegal},     32'd0);
    check({tag, "_timeout"},     {31'b0, bus.timeout},     32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1]  = 32'd20;
    regs[2]  = 32'd7;
    regs[6]  = 32'hFFFF_FF80;
    regs[7]  = 32'd1;
    regs[8]  = 32'hFFFF_FFFF;
    regs[9]  = 32'h0F0F_0F0F;
    regs[10] = 32'h0000_1234;

    // Reset state.
    repeat (3) @(negedge ck_ref);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge ck_ref);
    check("ready_after_reset", {31'b0, bus.instr_ready}, 32'd1);

    // SUB x3,x1,x2 : 20 - 7 = 13.
    exp_issue(4'b0010, 32'd20, 32'd7);
    exp_event(EV_WB, 5'd3, 32'd13);
    send(32'h402081B3, 1);
    wait_idle();

    // ADDI x1,x0,5 with latency checks.
    exp_issue(4'b0001, 32'd0, 32'd5);
    exp_event(EV_WB, 5'd1, 32'd5);
    send(32'h00500093, 1);
    @(negedge ck_ref);
    check("addi_alu_en_n1", {31'b0, bus.alu_en}, 32'd1);
    @(negedge ck_ref);
    check("addi_alu_en_n2", {31'b0, bus.alu_en}, 32'd0);
    check("addi_wb_en_n2",  {31'b0, bus.wb_en},  32'd0);
    @(negedge ck_ref);
    check("addi_wb_en_n3",  {31'b0, bus.wb_en},  32'd1);
    @(negedge ck_ref);
    check("addi_ready_n4",  {31'b0, bus.instr_ready}, 32'd1);
    check("addi_wb_addr_hold", {27'b0, bus.wb_addr}, 32'd1);
    check("addi_wb_data_hold", bus.wb_data, 32'd5);

    // ADD x2,x1,x1 with a stale regfile value for x1.
    regs[1] = 32'd0;
`ifdef ALU_ISSUE_BYPASS_EN
    exp_issue(4'b0001, 32'd5, 32'd5);
    exp_event(EV_WB, 5'd2, 32'd10);
`else
    exp_issue(4'b0001, 32'd0, 32'd0);
    exp_event(EV_WB, 5'd2, 32'd0);
`endif
    send(32'h00108133, 1);
    wait_idle();

    // SRAI x5,x6,3 : 0xFFFFFF80 >>> 3.
    exp_issue(4'b1000, 32'hFFFF_FF80, 32'd3);
    exp_event(EV_WB, 5'd5, 32'hFFFF_FFF0);
    send(32'h40335293, 1);
    wait_idle();

    // NOP: issues, no write-back, ready after 4 cycles.
    exp_issue(4'b0001, 32'd0, 32'd0);
    send(32'h00000013, 1);
    repeat (3) @(negedge ck_ref);
    check("nop_ready_n3", {31'b0, bus.instr_ready}, 32'd0);
    @(negedge ck_ref);
    check("nop_ready_n4", {31'b0, bus.instr_ready}, 32'd1);

    // ORI x9,x10,-2048 : sign-extended immediate.
    exp_issue(4'b0100, 32'h0000_1234, 32'hFFFF_F800);
    exp_event(EV_WB, 5'd9, 32'hFFFF_FA34);
    send(32'h80056493, 2);
    wait_idle();

    // Illegal: JAL, bad funct7 on ADD, SLLI with funct7 0100000.
    exp_event(EV_ILL, 5'd0, 32'd0);
    send(32'h0000006F, 1);
    wait_idle();
    exp_event(EV_ILL, 5'd0, 32'd0);
    send(32'h7E208133, 1);
    wait_idle();
    exp_event(EV_ILL, 5'd0, 32'd0);
    send(32'h40109093, 1);
    wait_idle();

    // SLTU x4,x7,x8 with done in the last WAIT cycle: done wins.
    exp_issue(4'b1010, 32'd1, 32'hFFFF_FFFF);
    exp_event(EV_WB, 5'd4, 32'd1);
    send(32'h0083B233, 16);
    wait_idle();

    // XOR x7,x8,x9 with done never arriving: timeout 16 cycles after alu_en.
    exp_issue(4'b0101, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    exp_event(EV_TO, 5'd0, 32'd0);
    send(32'h009443B3, -1);
    @(negedge ck_ref);
    check("to_alu_en", {31'b0, bus.alu_en}, 32'd1);
    n = 0;
    do begin
      @(negedge ck_ref);
      n++;
    end while (!bus.timeout && n < 40);
    check("timeout_latency", n, 32'd16);
    @(negedge ck_ref);
    check("ready_after_timeout", {31'b0, bus.instr_ready}, 32'd1);

    // AND x11,x12,x13 with done only during ISSUE: ignored, so it times out.
    exp_issue(4'b0011, 32'd0, 32'd0);
    exp_event(EV_TO, 5'd0, 32'd0);
    send(32'h00D675B3, 0);
    wait_idle();

    // Reset while in WAIT: outputs clear at once, no write-back follows.
    exp_issue(4'b0001, 32'd0, 32'd5);
    send(32'h00500093, -1);
    repeat (3) @(negedge ck_ref);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge ck_ref);
    rst = 1'b0;
    repeat (20) @(negedge ck_ref);
    check("ready_after_midreset", {31'b0, bus.instr_ready}, 32'd1);

    repeat (2) @(negedge ck_ref);
    check("issue_queue_drained", issue_q.size(), 32'd0);
    check("event_queue_drained", res_q.size(),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
